ssd1306_spi_tx: RTL

Byte-serial SPI transmitter that sits directly downstream of the SSD1306 init sequencer and any later command/data sources. It accepts one byte per start/ready handshake and shifts it MSB-first onto the panel's SPI pins (SCLK, SDIN, CSn). Chip select stays asserted across a burst and is released after the byte flagged as last. The block does not own D/C, RESn or VBATn; those stay with the sequencer.

---
 rtl/ssd1306_spi_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ssd1306_spi_tx.sv
// ssd1306_spi_tx: byte-serial SPI (mode 0, MSB first) transmitter for an SSD1306 panel.
// One byte is accepted per start/ready handshake. CSn stays low across a burst and
// is released after the byte flagged as last.
// Optional feature macro: SSD1306_SPI_CS_GAP_EN holds CSn high for CS_GAP cycles
// after a last byte before ready_out returns.
//
// state  | meaning
// IDLE   | ready for a byte; SCLK low, SDIN 0, CSn held from the previous byte
// LOW    | SCLK low half-period, SDIN carries the current bit
// HIGH   | SCLK high half-period, panel has sampled SDIN on the rising edge
// GAP    | CSn-high hold after a last byte (feature macro only)
module ssd1306_spi_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       start_in,
  input  logic [7:0] data_in,
  input  logic       last_byte_in,
  output logic       ready_out,
  output logic       oled_sclk,
  output logic       oled_sdin,
  output logic       oled_csn
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic       ready_q, ready_d;
  logic       csn_q, csn_d;
  logic       sclk_q, sclk_d;
  logic       sdin_q, sdin_d;

`ifdef SSD1306_SPI_CS_GAP_EN
  localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);
  logic [7:0] gcnt_q, gcnt_d;

  // gap counter register, only present with the CS-gap feature
  always_ff @(posedge clk_in) begin
    if (reset_in) gcnt_q <= '0;
    else          gcnt_q <= gcnt_d;
  end
`else
  // CS_GAP has no effect without the gap feature
  logic unused_cs_gap;
  assign unused_cs_gap = ^CS_GAP;
`endif

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
    end
  end

  // next-state and registered-output logic; SDIN only moves with SCLK falling or on accept
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    last_d  = last_q;
    ready_d = ready_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
`ifdef SSD1306_SPI_CS_GAP_EN
    gcnt_d  = gcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          data_d  = data_in;
          last_d  = last_byte_in;
          ready_d = 1'b0;
          csn_d   = 1'b0;
          sdin_d  = data_in[7];
          bit_d   = 3'd7;
          hcnt_d  = HALF_RELOAD;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (hcnt_q == 8'd0) begin
          sclk_d  = 1'b1;
          hcnt_d  = HALF_RELOAD;
          state_d = S_HIGH;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (hcnt_q == 8'd0) begin
          sclk_d = 1'b0;
          hcnt_d = HALF_RELOAD;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            sdin_d  = data_q[bit_q - 3'd1];
            state_d = S_LOW;
          end else begin
            sdin_d = 1'b0;
            if (!last_q) begin
              ready_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              csn_d = 1'b1;
`ifdef SSD1306_SPI_CS_GAP_EN
              gcnt_d  = GAP_RELOAD;
              state_d = S_GAP;
`else
              ready_d = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
`ifdef SSD1306_SPI_CS_GAP_EN
      S_GAP: begin
        if (gcnt_q == 8'd0) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign ready_out = ready_q;
  assign oled_sclk = sclk_q;
  assign oled_sdin = sdin_q;
  assign oled_csn  = csn_q;

endmodule
